// File: rtl/uart_rx_axi_pkg.sv
// Shared types and constants for the UART receive FIFO AXI read slave.
package uart_rx_axi_pkg;

  typedef enum logic [0:0] {
    IDLE       = 1'b0,
    DATA_PHASE = 1'b1
  } state_t;

  localparam logic SEL_DATA   = 1'b0;
  localparam logic SEL_STATUS = 1'b1;

  // STATUS register layout
  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_IRQ     = 3;
  localparam int unsigned ST_CNT_LSB = 8;
  localparam int unsigned ST_CNT_W   = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit wrapping pointers; push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    push,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    pop,
  output logic [DATA_W-1:0]       head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count == PW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_axi_fifo.sv
// UART receive FIFO behind a two-register AXI-style burst read slave (DATA, STATUS).
// Optional UART_RX_IRQ_EN adds a registered threshold/overflow interrupt.
module uart_rx_axi_fifo
  import uart_rx_axi_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned RDATA_W = 32
`ifdef UART_RX_IRQ_EN
  , parameter int unsigned IRQ_THRESH = DEPTH / 2
`endif
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [DATA_W-1:0]  data,
  input  logic               valid,
  input  logic [ADDR_W-1:0]  araddr,
  input  logic [7:0]         arlen,
  input  logic               arvalid,
  output logic               arready,
  output logic [RDATA_W-1:0] rdata,
  output logic               rvalid,
  input  logic               rready,
  output logic               rlast,
  output logic [1:0]         rresp
`ifdef UART_RX_IRQ_EN
  , output logic             irq
`endif
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;

  state_t            state;
  state_t            state_nxt;
  logic              sel;
  logic [7:0]        beats_left;
  logic              overflow;
  logic [DATA_W-1:0] head;
  logic [PW-1:0]     count;
  logic              full;
  logic              empty;
  logic              beat_hs;
  logic              fifo_pop;
  logic              status_hs;
  logic              drop;
  logic              irq_bit;
  logic              unused_addr;

  assign unused_addr = ^{araddr[ADDR_W-1:3], araddr[1:0]};
  assign rresp       = 2'b00;

  assign beat_hs   = (state == DATA_PHASE) && rready;
  assign fifo_pop  = beat_hs && (sel == SEL_DATA) && !empty;
  assign status_hs = beat_hs && (sel == SEL_STATUS);
  assign drop      = valid && full && !fifo_pop;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (valid),
    .wdata (data),
    .pop   (fifo_pop),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (arvalid) state_nxt = DATA_PHASE;
      DATA_PHASE: if (rready && (beats_left == 8'd0)) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping captured at the AR handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel        <= SEL_DATA;
      beats_left <= 8'd0;
    end else if ((state == IDLE) && arvalid) begin
      sel        <= araddr[2];
      beats_left <= arlen;
    end else if (beat_hs && (beats_left != 8'd0)) begin
      beats_left <= beats_left - 8'd1;
    end
  end

  // A push dropped in the same cycle as a STATUS read keeps overflow set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (status_hs) overflow <= 1'b0;
  end

`ifdef UART_RX_IRQ_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) irq <= 1'b0;
    else       irq <= (32'(count) >= IRQ_THRESH) || overflow;
  end
  assign irq_bit = irq;
`else
  assign irq_bit = 1'b0;
`endif

  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rdata   = '0;
    case (state)
      IDLE: arready = 1'b1;
      DATA_PHASE: begin
        rvalid = 1'b1;
        rlast  = (beats_left == 8'd0);
        if (sel == SEL_DATA) begin
          if (empty) rdata[DATA_W] = 1'b1;
          else       rdata[DATA_W-1:0] = head;
        end else begin
          rdata[ST_EMPTY] = empty;
          rdata[ST_FULL]  = full;
          rdata[ST_OVF]   = overflow;
          rdata[ST_IRQ]   = irq_bit;
          rdata[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(count);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_axi_fifo.sv
// Directed self-checking bench for uart_rx_axi_fifo (DEPTH=16, optional irq path).
module tb_uart_rx_axi_fifo;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  data;
  logic        valid;
  logic [3:0]  araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic        rlast;
  logic [1:0]  rresp;
`ifdef UART_RX_IRQ_EN
  logic        irq;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_axi_fifo dut (
    .clk     (clk),
    .rstn    (rstn),
    .data    (data),
    .valid   (valid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .rready  (rready),
    .rlast   (rlast),
    .rresp   (rresp)
`ifdef UART_RX_IRQ_EN
    , .irq   (irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    data  = b;
    valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  task automatic ar_req(input logic is_status, input logic [7:0] len);
    check("arready_idle", 32'(arready), 32'd1);
    araddr  = is_status ? 4'h4 : 4'h0;
    arlen   = len;
    arvalid = 1'b1;
    step();
    arvalid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] exp_data, input logic exp_last);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_rdata"}, rdata, exp_data);
    check({tag, "_rlast"}, 32'(rlast), 32'(exp_last));
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    ar_req(1'b1, 8'd0);
    beat(tag, exp, 1'b1);
  endtask

  initial begin
    rstn = 1'b0; data = '0; valid = 1'b0; araddr = '0; arlen = '0;
    arvalid = 1'b0; rready = 1'b0;
    #12;
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Single DATA read, then STATUS shows two remaining
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    ar_req(1'b0, 8'd0);
    beat("single", 32'h41, 1'b1);
    check("idle_rvalid", 32'(rvalid), 32'd0);
    check("idle_rdata", rdata, 32'd0);
    read_status("st_cnt2", 32'h0000_0200);
    ar_req(1'b0, 8'd1);
    beat("drain0", 32'h42, 1'b0);
    beat("drain1", 32'h43, 1'b1);
    read_status("st_empty", 32'h0000_0001);

    // Burst longer than contents: 4th beat reports empty flag
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    ar_req(1'b0, 8'd3);
    beat("burst0", 32'h41, 1'b0);
    beat("burst1", 32'h42, 1'b0);
    beat("burst2", 32'h43, 1'b0);
    beat("burst3", 32'h100, 1'b1);
    read_status("st_after_burst", 32'h0000_0001);

    // Overflow: 17 pushes into 16 entries, byte 0x20 lost
    for (int i = 0; i < 17; i++) push_byte(8'(8'h10 + i));
    read_status("st_ovf", 32'h0000_1006);
    read_status("st_ovf_clr", 32'h0000_1002);

    // Full: push and pop in the same cycle
    ar_req(1'b0, 8'd0);
    data = 8'hEE; valid = 1'b1;
    beat("full_pp", 32'h10, 1'b1);
    valid = 1'b0;
    read_status("st_full_pp", 32'h0000_1002);
    ar_req(1'b0, 8'd15);
    for (int i = 1; i < 16; i++) beat("full_drain", 32'(8'h10 + i), 1'b0);
    beat("full_drain_last", 32'hEE, 1'b1);
    read_status("st_drained", 32'h0000_0001);

    // Stall mid-burst, then async reset mid-burst
    push_byte(8'hA0); push_byte(8'hA1); push_byte(8'hA2);
    ar_req(1'b0, 8'd2);
    beat("stall0", 32'hA0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stall_rvalid", 32'(rvalid), 32'd1);
      check("stall_rdata", rdata, 32'hA1);
      check("stall_rlast", 32'(rlast), 32'd0);
      step();
    end
    #2 rstn = 1'b0;
    #1;
    check("arst_rvalid", 32'(rvalid), 32'd0);
    check("arst_arready", 32'(arready), 32'd1);
    check("arst_rdata", rdata, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    read_status("st_after_rst", 32'h0000_0001);

`ifdef UART_RX_IRQ_EN
    for (int i = 0; i < 7; i++) push_byte(8'(8'h50 + i));
    step();
    check("irq_below", 32'(irq), 32'd0);
    push_byte(8'h57);
    check("irq_same_cycle", 32'(irq), 32'd0);
    step();
    check("irq_rise", 32'(irq), 32'd1);
    ar_req(1'b0, 8'd0);
    beat("irq_pop", 32'h50, 1'b1);
    step();
    check("irq_fall", 32'(irq), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
